vga_box_renderer: RTL

//  Consumer of the VGA timing generator's row_i/col_i/sync_h/sync_v/blank_n.

---
 rtl/vga_pkg.sv | 24 ++
 rtl/vga_box_if.sv | 26 ++
 rtl/vga_box_motion.sv | 49 ++++
 rtl/vga_box_renderer.sv | 110 +++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// Shared types, colours and defaults for the VGA box renderer and its motion axes.
package vga_pkg;

   localparam int unsigned DEFAULT_VIS_W = 640;
   localparam int unsigned DEFAULT_VIS_H = 480;

   typedef logic [11:0] rgb12_t;

   localparam rgb12_t COL_BLACK = 12'h000;
   localparam rgb12_t COL_WHITE = 12'hFFF;
   localparam rgb12_t COL_GREY  = 12'h222;

   typedef enum logic {
      FWD = 1'b0,
      REV = 1'b1
   } dir_e;

   // 11-bit zero-extended window test so lo+size can never wrap.
   function automatic logic in_span(input logic [9:0] v, input logic [9:0] lo,
                                    input logic [10:0] size);
      return ({1'b0, v} >= {1'b0, lo}) && ({1'b0, v} < ({1'b0, lo} + size));
   endfunction

endpackage

// File: rtl/vga_box_if.sv
// Pixel-stream bundle between the timing generator side and the renderer.
interface vga_box_if;
   logic [9:0] row_i;
   logic [9:0] col_i;
   logic       sync_h_i;
   logic       sync_v_i;
   logic       blank_n_i;
   logic       pause;
   logic [3:0] vga_r;
   logic [3:0] vga_g;
   logic [3:0] vga_b;
   logic       vga_hs;
   logic       vga_vs;
   logic       vga_blank_n;
   logic       frame_tick;

   modport master (
      output row_i, col_i, sync_h_i, sync_v_i, blank_n_i, pause,
      input  vga_r, vga_g, vga_b, vga_hs, vga_vs, vga_blank_n, frame_tick
   );

   modport slave (
      input  row_i, col_i, sync_h_i, sync_v_i, blank_n_i, pause,
      output vga_r, vga_g, vga_b, vga_hs, vga_vs, vga_blank_n, frame_tick
   );
endinterface

// File: rtl/vga_box_motion.sv
// One bouncing axis: advances pos by STEP per tick and reflects off 0 and LIMIT-SIZE.
module vga_box_motion
   import vga_pkg::*;
#(
   parameter int unsigned LIMIT = 640,
   parameter int unsigned SIZE  = 32,
   parameter int unsigned STEP  = 2
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       tick,
   input  logic       pause,
   output logic [9:0] pos
);

   dir_e dir;

   // Direction FSM and position; the far edge clamps so the box never leaves the screen.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         pos <= 10'd0;
         dir <= FWD;
      end else if (tick && !pause) begin
         case (dir)
            FWD: begin
               if (({1'b0, pos} + 11'(STEP + SIZE)) >= 11'(LIMIT)) begin
                  pos <= 10'(LIMIT - SIZE);
                  dir <= REV;
               end else begin
                  pos <= pos + 10'(STEP);
               end
            end
            REV: begin
               if (pos <= 10'(STEP)) begin
                  pos <= 10'd0;
                  dir <= FWD;
               end else begin
                  pos <= pos - 10'(STEP);
               end
            end
            default: begin
               pos <= 10'd0;
               dir <= FWD;
            end
         endcase
      end
   end

endmodule

// File: rtl/vga_box_renderer.sv
// Two-stage renderer: border, checkerboard and a bouncing box, with sync/blank delayed to match.
module vga_box_renderer
   import vga_pkg::*;
#(
   parameter int unsigned VIS_W     = DEFAULT_VIS_W,
   parameter int unsigned VIS_H     = DEFAULT_VIS_H,
   parameter int unsigned BOX_SIZE  = 32,
   parameter int unsigned STEP      = 2,
   parameter rgb12_t      BOX_COLOR = 12'hF00,
   parameter int unsigned CHECK_BIT = 5
) (
   input logic      clk,
   input logic      reset_n,
   vga_box_if.slave bus
);

   logic [9:0] s1_row;
   logic [9:0] s1_col;
   logic       s1_hs;
   logic       s1_vs;
   logic       s1_blank_n;
   logic       s1_tick;
   logic [9:0] box_x;
   logic [9:0] box_y;
   rgb12_t     mix;
   rgb12_t     s2_rgb;
   logic       s2_hs;
   logic       s2_vs;
   logic       s2_blank_n;
   logic       s2_tick;

   // Stage 1: capture generator counters and flag the first vertical-blank pixel.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         s1_row     <= 10'd0;
         s1_col     <= 10'd0;
         s1_hs      <= 1'b1;
         s1_vs      <= 1'b1;
         s1_blank_n <= 1'b0;
         s1_tick    <= 1'b0;
      end else begin
         s1_row     <= bus.row_i;
         s1_col     <= bus.col_i;
         s1_hs      <= bus.sync_h_i;
         s1_vs      <= bus.sync_v_i;
         s1_blank_n <= bus.blank_n_i;
         s1_tick    <= (bus.row_i == 10'(VIS_H)) && (bus.col_i == 10'd0);
      end
   end

   vga_box_motion #(.LIMIT(VIS_W), .SIZE(BOX_SIZE), .STEP(STEP)) u_motion_x (
      .clk     (clk),
      .reset_n (reset_n),
      .tick    (s1_tick),
      .pause   (bus.pause),
      .pos     (box_x)
   );

   vga_box_motion #(.LIMIT(VIS_H), .SIZE(BOX_SIZE), .STEP(STEP)) u_motion_y (
      .clk     (clk),
      .reset_n (reset_n),
      .tick    (s1_tick),
      .pause   (bus.pause),
      .pos     (box_y)
   );

   // Colour priority: blanking, box, border, checkerboard.
   always_comb begin
      mix = COL_BLACK;
      if (!s1_blank_n) begin
         mix = COL_BLACK;
      end else if (in_span(s1_col, box_x, 11'(BOX_SIZE)) &&
                   in_span(s1_row, box_y, 11'(BOX_SIZE))) begin
         mix = BOX_COLOR;
      end else if ((s1_col == 10'd0) || (s1_col == 10'(VIS_W - 1)) ||
                   (s1_row == 10'd0) || (s1_row == 10'(VIS_H - 1))) begin
         mix = COL_WHITE;
      end else if (s1_col[CHECK_BIT] ^ s1_row[CHECK_BIT]) begin
         mix = COL_GREY;
      end else begin
         mix = COL_BLACK;
      end
   end

   // Stage 2: registered colour plus sync/blank/tick delayed to the same latency.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         s2_rgb     <= COL_BLACK;
         s2_hs      <= 1'b1;
         s2_vs      <= 1'b1;
         s2_blank_n <= 1'b0;
         s2_tick    <= 1'b0;
      end else begin
         s2_rgb     <= mix;
         s2_hs      <= s1_hs;
         s2_vs      <= s1_vs;
         s2_blank_n <= s1_blank_n;
         s2_tick    <= s1_tick;
      end
   end

   assign bus.vga_r       = s2_rgb[11:8];
   assign bus.vga_g       = s2_rgb[7:4];
   assign bus.vga_b       = s2_rgb[3:0];
   assign bus.vga_hs      = s2_hs;
   assign bus.vga_vs      = s2_vs;
   assign bus.vga_blank_n = s2_blank_n;
   assign bus.frame_tick  = s2_tick;

endmodule
